tlp_send: RTL and testbench

//  Downstream partner of the TLP receiver. Buffers the receiver's Action stream (no back-pressure

---
 rtl/tlp_send_pkg.sv | 86 ++++++++
 rtl/tlp_send_if.sv | 29 ++
 rtl/tlp_act_fifo.sv | 64 ++++++
 rtl/tlp_send.sv | 184 ++++++++++++++++++
 tb/tb_tlp_send.sv | 570 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlp_send_pkg.sv
// Shared types for the TLP send path: action words from the receiver, the send FSM state
// encoding and the three header/data dwords of a 1-DW completion TLP.
package tlp_send_pkg;

  typedef enum logic [1:0] {
    ACT_NOP   = 2'd0,
    REG_READ  = 2'd1,
    REG_WRITE = 2'd2
  } ActionType;

  typedef logic [3:0] ExtChan;

  // actType is carried raw so that undefined encodings survive to the sender and get discarded.
  typedef struct packed {
    logic [1:0]  actType;
    ExtChan      chan;
    logic [15:0] reqID;
    logic [7:0]  tag;
    logic [31:0] data;
  } Action;

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StCmp0,
    StCmp1,
    StCmp2
  } SendState;

  localparam logic [2:0]  FMT_H3DW_WITHDATA  = 3'b010;
  localparam logic [4:0]  TYP_COMPLETION     = 5'b01010;
  localparam logic [2:0]  CPL_STATUS_SC      = 3'b000;
  localparam logic [9:0]  CPL_LENGTH_1DW     = 10'd1;
  localparam logic [11:0] CPL_BYTE_COUNT_1DW = 12'd4;

  // Header DW0.
  typedef struct packed {
    logic [2:0] fmt;
    logic [4:0] typ;
    logic       rsvd0;
    logic [2:0] tc;
    logic [3:0] rsvd1;
    logic       td;
    logic       ep;
    logic [1:0] attr;
    logic [1:0] at;
    logic [9:0] length;
  } Completion0;

  // Header DW1.
  typedef struct packed {
    logic [15:0] completerID;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] byteCount;
  } Completion1;

  // Header DW2.
  typedef struct packed {
    logic [15:0] reqID;
    logic [7:0]  tag;
    logic        rsvd;
    logic [6:0]  lowerAddr;
  } Completion2;

  function automatic ActionType getActType(input Action a);
    return ActionType'(a.actType);
  endfunction

  function automatic ExtChan getActChan(input Action a);
    return a.chan;
  endfunction

  function automatic logic [31:0] getActData(input Action a);
    return a.data;
  endfunction

  function automatic logic [15:0] getActReqID(input Action a);
    return a.reqID;
  endfunction

  function automatic logic [7:0] getActTag(input Action a);
    return a.tag;
  endfunction

endpackage

// File: rtl/tlp_send_if.sv
// Avalon-ST TX beat interface between tlp_send (master) and the PCIe hard-IP TX port (slave).
//  txData   64  TLP beat
//  txValid  1   beat valid
//  txReady  1   sink accepts beat when txValid && txReady
//  txSOP    1   first beat of TLP
//  txEOP    1   last beat of TLP
interface tlp_send_if;
  logic [63:0] txData;
  logic        txValid;
  logic        txReady;
  logic        txSOP;
  logic        txEOP;

  modport master (
    output txData,
    output txValid,
    output txSOP,
    output txEOP,
    input  txReady
  );

  modport slave (
    input  txData,
    input  txValid,
    input  txSOP,
    input  txEOP,
    output txReady
  );
endinterface

// File: rtl/tlp_act_fifo.sv
// Synchronous FIFO of Action words with a sticky overflow flag.
//  clk_in       clock
//  rstN_in      asynchronous active-low reset
//  push_in      write strobe; ignored (and flagged) when full
//  pushData_in  action to write
//  pop_in       read strobe; ignored when empty
//  head_out     oldest entry (valid while !empty_out)
//  full_out     DEPTH entries held
//  empty_out    no entries held
//  overflow_out sticky: a push arrived while full
// DEPTH must be a power of two and at least 2.
module tlp_act_fifo
  import tlp_send_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clk_in,
  input  logic  rstN_in,
  input  logic  push_in,
  input  Action pushData_in,
  input  logic  pop_in,
  output Action head_out,
  output logic  full_out,
  output logic  empty_out,
  output logic  overflow_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  Action       mem [DEPTH];
  logic [AW:0] wrPtrQ, rdPtrQ;
  logic        overflowQ;
  logic        doPush, doPop;

  // Extra MSB on each pointer separates full (MSBs differ) from empty (pointers equal).
  assign empty_out = (wrPtrQ == rdPtrQ);
  assign full_out  = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);

  // Push is judged against the pre-pop full flag: no same-cycle push+pop when full.
  assign doPush = push_in && !full_out;
  assign doPop  = pop_in && !empty_out;

  always_ff @(posedge clk_in or negedge rstN_in) begin
    if (!rstN_in) begin
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      overflowQ <= 1'b0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + PtrOne;
      if (doPop)  rdPtrQ <= rdPtrQ + PtrOne;
      if (push_in && full_out) overflowQ <= 1'b1;
    end
  end

  // Storage needs no reset; empty_out gates every use of the head.
  always_ff @(posedge clk_in) begin
    if (doPush) mem[wrPtrQ[AW-1:0]] <= pushData_in;
  end

  assign head_out     = mem[rdPtrQ[AW-1:0]];
  assign overflow_out = overflowQ;

endmodule

// File: rtl/tlp_send.sv
// Downstream partner of the TLP receiver. Queues actions, performs register writes directly and
// turns register reads into 1-DW completion TLPs on the 64-bit Avalon-ST TX port.
//  pcieClk_in       core clock
//  pcieRstN_in      asynchronous active-low reset (deasserted synchronously inside)
//  cfgBusDev_in     {bus, dev} of this function; function number is always 0
//  actData_in       action word from receiver
//  actValid_in      action strobe; accepted unless the FIFO is full
//  actOverflow_out  sticky: an action was dropped on a full FIFO
//  regWr*_out       1-cycle register write strobe with channel/data
//  regRdChan_out    register channel for reads
//  regRdReq_out     1-cycle read request strobe
//  regRdData_in     read data, qualified by regRdValid_in
//  txIf             Avalon-ST TX beats (master side)
module tlp_send
  import tlp_send_pkg::*;
#(
  parameter int unsigned ACT_FIFO_DEPTH = 8
) (
  input  logic              pcieClk_in,
  input  logic              pcieRstN_in,
  input  logic [12:0]       cfgBusDev_in,
  input  Action             actData_in,
  input  logic              actValid_in,
  output logic              actOverflow_out,
  output ExtChan            regWrChan_out,
  output logic [31:0]       regWrData_out,
  output logic              regWrValid_out,
  output ExtChan            regRdChan_out,
  output logic              regRdReq_out,
  input  logic [31:0]       regRdData_in,
  input  logic              regRdValid_in,
  tlp_send_if.master        txIf
);

  // Reset synchroniser: assertion passes straight through, release is retimed to the clock.
  logic [1:0] rstSyncQ;
  logic       rstN;

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) rstSyncQ <= 2'b00;
    else              rstSyncQ <= {rstSyncQ[0], 1'b1};
  end

  assign rstN = rstSyncQ[1];

  // Action FIFO
  Action fifoHead;
  logic  fifoFull, fifoEmpty, fifoPop;

  tlp_act_fifo #(
    .DEPTH(ACT_FIFO_DEPTH)
  ) u_actFifo (
    .clk_in      (pcieClk_in),
    .rstN_in     (rstN),
    .push_in     (actValid_in),
    .pushData_in (actData_in),
    .pop_in      (fifoPop),
    .head_out    (fifoHead),
    .full_out    (fifoFull),
    .empty_out   (fifoEmpty),
    .overflow_out(actOverflow_out)
  );

  // Send FSM state and the context of the read in flight
  SendState    stateQ, stateD;
  ExtChan      chanQ, chanD;
  logic [15:0] reqIdQ, reqIdD;
  logic [7:0]  tagQ, tagD;
  logic [31:0] rdDataQ, rdDataD;

  always_ff @(posedge pcieClk_in or negedge rstN) begin
    if (!rstN) begin
      stateQ  <= StIdle;
      chanQ   <= '0;
      reqIdQ  <= '0;
      tagQ    <= '0;
      rdDataQ <= '0;
    end else begin
      stateQ  <= stateD;
      chanQ   <= chanD;
      reqIdQ  <= reqIdD;
      tagQ    <= tagD;
      rdDataQ <= rdDataD;
    end
  end

  // Completion header fields
  Completion0 cpl0;
  Completion1 cpl1;
  Completion2 cpl2;

  always_comb begin
    cpl0             = '0;
    cpl0.fmt         = FMT_H3DW_WITHDATA;
    cpl0.typ         = TYP_COMPLETION;
    cpl0.length      = CPL_LENGTH_1DW;
    cpl1             = '0;
    cpl1.completerID = {cfgBusDev_in, 3'b000};
    cpl1.status      = CPL_STATUS_SC;
    cpl1.bcm         = 1'b0;
    cpl1.byteCount   = CPL_BYTE_COUNT_1DW;
    cpl2             = '0;
    cpl2.reqID       = reqIdQ;
    cpl2.tag         = tagQ;
    // Each channel is one qword apart, so lower address is chan * 8.
    cpl2.lowerAddr   = {chanQ, 3'b000};
  end

  logic [63:0] txData;
  logic        txValid, txSOP, txEOP;

  always_comb begin
    stateD         = stateQ;
    chanD          = chanQ;
    reqIdD         = reqIdQ;
    tagD           = tagQ;
    rdDataD        = rdDataQ;
    fifoPop        = 1'b0;
    regWrChan_out  = '0;
    regWrData_out  = '0;
    regWrValid_out = 1'b0;
    regRdChan_out  = '0;
    regRdReq_out   = 1'b0;
    txData         = '0;
    txValid        = 1'b0;
    txSOP          = 1'b0;
    txEOP          = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          case (getActType(fifoHead))
            REG_WRITE: begin
              regWrValid_out = 1'b1;
              regWrChan_out  = getActChan(fifoHead);
              regWrData_out  = getActData(fifoHead);
            end
            REG_READ: begin
              regRdReq_out  = 1'b1;
              regRdChan_out = getActChan(fifoHead);
              chanD         = getActChan(fifoHead);
              reqIdD        = getActReqID(fifoHead);
              tagD          = getActTag(fifoHead);
              stateD        = StRdWait;
            end
            default: ;  // NOP or undefined encoding: dropped
          endcase
        end
      end
      StRdWait: begin
        if (regRdValid_in) begin
          rdDataD = regRdData_in;
          stateD  = StCmp0;
        end
      end
      StCmp0: begin
        txValid = 1'b1;
        txSOP   = 1'b1;
        txData  = {cpl1, cpl0};
        if (txIf.txReady) stateD = StCmp1;
      end
      StCmp1: begin
        txValid = 1'b1;
        txData  = {32'h0, cpl2};
        if (txIf.txReady) stateD = StCmp2;
      end
      StCmp2: begin
        // 3DW header with a qword-aligned address puts the data in the next qword.
        txValid = 1'b1;
        txEOP   = 1'b1;
        txData  = {32'h0, rdDataQ};
        if (txIf.txReady) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  assign txIf.txData  = txData;
  assign txIf.txValid = txValid;
  assign txIf.txSOP   = txSOP;
  assign txIf.txEOP   = txEOP;

endmodule

// File: tb/tb_tlp_send.sv
module tb_tlp_send;
  import tlp_send_pkg::*;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [12:0] busDev = {8'h01, 5'h00};
  Action       actData = '0;
  logic        actValid = 1'b0;
  logic        actOverflow;
  ExtChan      wrChan;
  logic [31:0] wrData;
  logic        wrValid;
  ExtChan      rdChan;
  logic        rdReq;
  logic [31:0] rdData;
  logic        rdValid;

  tlp_send_if txIf ();

  tlp_send #(
    .ACT_FIFO_DEPTH(8)
  ) dut (
    .pcieClk_in     (clk),
    .pcieRstN_in    (rstN),
    .cfgBusDev_in   (busDev),
    .actData_in     (actData),
    .actValid_in    (actValid),
    .actOverflow_out(actOverflow),
    .regWrChan_out  (wrChan),
    .regWrData_out  (wrData),
    .regWrValid_out (wrValid),
    .regRdChan_out  (rdChan),
    .regRdReq_out   (rdReq),
    .regRdData_in   (rdData),
    .regRdValid_in  (rdValid),
    .txIf           (txIf)
  );

  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          isCpl;
    logic [63:0] b0;
    logic [63:0] b1;
    logic [63:0] b2;
    int          cycle;
  } Ev;

  Ev           obsQ[$];
  Ev           expQ[$];
  logic [31:0] devRegs   [16];
  logic [31:0] modelRegs [16];

  // Monitor: register-file side effects, accepted TLPs, stall/continuity rules
  Ev           monEv;
  logic [63:0] beatBuf [3];
  int          beatIdx = 0;
  bit          inTlp = 0;
  bit          prevValid = 0, prevReady = 0, prevSop = 0, prevEop = 0;
  logic [63:0] prevData = '0;
  int          stallErr = 0, tlpErr = 0, beatCnt = 0, rdReqCyc = 0, sopCyc = 0;

  always @(negedge clk) begin
    if (!rstN) begin
      inTlp     = 0;
      prevValid = 0;
      prevReady = 0;
    end else begin
      if (wrValid) begin
        devRegs[wrChan] = wrData;
        monEv.isCpl = 0;
        monEv.b0    = {28'h0, wrChan, wrData};
        monEv.b1    = '0;
        monEv.b2    = '0;
        monEv.cycle = cyc;
        obsQ.push_back(monEv);
      end
      if (rdReq) rdReqCyc = cyc;
      if (prevValid && !prevReady) begin
        if (!txIf.txValid || txIf.txData !== prevData || txIf.txSOP !== prevSop ||
            txIf.txEOP !== prevEop) stallErr++;
      end
      if (txIf.txValid && txIf.txSOP && !prevValid) sopCyc = cyc;
      if (inTlp && !txIf.txValid) tlpErr++;
      if (txIf.txValid && txIf.txReady) begin
        beatCnt++;
        if (txIf.txSOP) begin
          beatIdx = 0;
          inTlp   = 1;
        end
        if (beatIdx < 3) beatBuf[beatIdx] = txIf.txData;
        beatIdx++;
        if (txIf.txEOP) begin
          inTlp       = 0;
          monEv.isCpl = 1;
          monEv.b0    = beatBuf[0];
          monEv.b1    = beatBuf[1];
          monEv.b2    = (beatIdx == 3) ? beatBuf[2] : 64'hx;
          monEv.cycle = cyc;
          obsQ.push_back(monEv);
        end
      end
      prevValid = txIf.txValid;
      prevReady = txIf.txReady;
      prevData  = txIf.txData;
      prevSop   = txIf.txSOP;
      prevEop   = txIf.txEOP;
    end
  end

  // TX sink ready: 0 = always ready, 1 = toggling, 2 = random
  int readyMode = 0;
  initial begin
    txIf.txReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       txIf.txReady = 1'b1;
        1:       txIf.txReady = ~txIf.txReady;
        default: txIf.txReady = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Register-file read responder; rdLat 0 means random latency 1..4
  bit     rdHold = 0;
  int     rdLat = 0;
  ExtChan respChan;
  int     respDly;
  initial begin
    rdValid = 1'b0;
    rdData  = '0;
    forever begin
      @(negedge clk);
      if (rstN && rdReq) begin
        respChan = rdChan;
        respDly  = (rdLat > 0) ? rdLat : int'($urandom_range(1, 4));
        while (rdHold) @(posedge clk);
        repeat (respDly) @(posedge clk);
        #1;
        rdValid = 1'b1;
        rdData  = devRegs[respChan];
        @(posedge clk);
        #1;
        rdValid = 1'b0;
        rdData  = '0;
      end
    end
  end

  // Stimulus helpers and the reference model
  int lastPushCyc = 0;

  task automatic pushAct(input Action a);
    lastPushCyc = cyc;
    actData     = a;
    actValid    = 1'b1;
    @(posedge clk);
    #1;
    actValid = 1'b0;
  endtask

  function automatic Action mkAct(input logic [1:0] t, input ExtChan ch, input logic [15:0] rid,
                                  input logic [7:0] tg, input logic [31:0] d);
    Action a;
    a.actType = t;
    a.chan    = ch;
    a.reqID   = rid;
    a.tag     = tg;
    a.data    = d;
    return a;
  endfunction

  function automatic Action randAct(input int forceType);
    int r;
    logic [1:0] t;
    r = int'($urandom_range(0, 9));
    if (forceType >= 0) t = 2'(forceType);
    else if (r < 4)     t = 2'd1;
    else if (r < 8)     t = 2'd2;
    else if (r == 8)    t = 2'd0;
    else                t = 2'd3;
    return mkAct(t, 4'($urandom), 16'($urandom), 8'($urandom), $urandom);
  endfunction

  // Reads return the current register value; writes update it; anything else has no effect.
  task automatic modelAct(input Action a);
    Ev e;
    e.cycle = 0;
    if (a.actType == 2'd2) begin
      modelRegs[a.chan] = a.data;
      e.isCpl = 0;
      e.b0    = {28'h0, a.chan, a.data};
      e.b1    = '0;
      e.b2    = '0;
      expQ.push_back(e);
    end else if (a.actType == 2'd1) begin
      e.isCpl = 1;
      e.b0    = {busDev, 3'b000, 16'h0004, 32'h4A00_0001};
      e.b1    = {32'h0, a.reqID, a.tag, 8'(a.chan * 8)};
      e.b2    = {32'h0, modelRegs[a.chan]};
      expQ.push_back(e);
    end
  endtask

  task automatic seedRegs();
    for (int i = 0; i < 16; i++) begin
      devRegs[i]   = $urandom;
      modelRegs[i] = devRegs[i];
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic doReset();
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Tests
  task automatic test_reset();
    rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    totalCnt++;
    if (txIf.txValid !== 1'b0) $display("FAIL rst_txValid: got %b want 0", txIf.txValid);
    else passCnt++;
    totalCnt++;
    if (txIf.txSOP !== 1'b0 || txIf.txEOP !== 1'b0)
      $display("FAIL rst_sopeop: got %b%b want 00", txIf.txSOP, txIf.txEOP);
    else passCnt++;
    totalCnt++;
    if (txIf.txData !== 64'h0) $display("FAIL rst_txData: got %h want 0", txIf.txData);
    else passCnt++;
    totalCnt++;
    if (wrValid !== 1'b0 || wrData !== 32'h0 || wrChan !== 4'h0)
      $display("FAIL rst_wr: got %b %h %h want 0 0 0", wrValid, wrChan, wrData);
    else passCnt++;
    totalCnt++;
    if (rdReq !== 1'b0 || rdChan !== 4'h0)
      $display("FAIL rst_rd: got %b %h want 0 0", rdReq, rdChan);
    else passCnt++;
    totalCnt++;
    if (actOverflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", actOverflow);
    else passCnt++;
    doReset();
  endtask

  task automatic test_write();
    obsQ.delete();
    pushAct(mkAct(2'd2, 4'd5, 16'h0, 8'h0, 32'hDEADBEEF));
    @(negedge clk);
    totalCnt++;
    if (wrValid !== 1'b1 || cyc != lastPushCyc + 1)
      $display("FAIL wr_strobe: got valid %b at cycle %0d want 1 at %0d", wrValid, cyc,
               lastPushCyc + 1);
    else passCnt++;
    totalCnt++;
    if (wrChan !== 4'd5 || wrData !== 32'hDEADBEEF)
      $display("FAIL wr_fields: got chan %0d data %h want 5 DEADBEEF", wrChan, wrData);
    else passCnt++;
    totalCnt++;
    if (txIf.txValid !== 1'b0 || rdReq !== 1'b0)
      $display("FAIL wr_notx: got txValid %b rdReq %b want 0 0", txIf.txValid, rdReq);
    else passCnt++;
    @(negedge clk);
    totalCnt++;
    if (wrValid !== 1'b0) $display("FAIL wr_onecycle: got %b want 0", wrValid);
    else passCnt++;
    repeat (5) @(negedge clk);
    totalCnt++;
    if (obsQ.size() != 1) $display("FAIL wr_count: got %0d events want 1", obsQ.size());
    else passCnt++;
  endtask

  // Shared by the directed read and the stalled read; checks are inline in each caller.
  task automatic runDirectedRead();
    devRegs[3] = 32'hCAFEF00D;
    busDev     = {8'h01, 5'h00};
    rdLat      = 2;
    obsQ.delete();
    beatCnt  = 0;
    stallErr = 0;
    tlpErr   = 0;
    @(posedge clk);
    #1;
    pushAct(mkAct(2'd1, 4'd3, 16'h0100, 8'h2A, 32'h0));
    for (int i = 0; i < 200 && obsQ.size() < 1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    rdLat = 0;
  endtask

  task automatic test_read();
    readyMode = 0;
    runDirectedRead();
    totalCnt++;
    if (obsQ.size() != 1) $display("FAIL rd_count: got %0d events want 1", obsQ.size());
    else passCnt++;
    if (obsQ.size() > 0) begin
      totalCnt++;
      if (obsQ[0].b0 !== 64'h01000004_4A000001)
        $display("FAIL rd_beat0: got %h want 010000044A000001", obsQ[0].b0);
      else passCnt++;
      totalCnt++;
      if (obsQ[0].b1 !== 64'h00000000_01002A18)
        $display("FAIL rd_beat1: got %h want 0000000001002A18", obsQ[0].b1);
      else passCnt++;
      totalCnt++;
      if (obsQ[0].b2 !== 64'h00000000_CAFEF00D)
        $display("FAIL rd_beat2: got %h want 00000000CAFEF00D", obsQ[0].b2);
      else passCnt++;
    end
    totalCnt++;
    if (rdReqCyc != lastPushCyc + 1)
      $display("FAIL rd_popcycle: got %0d want %0d", rdReqCyc, lastPushCyc + 1);
    else passCnt++;
    totalCnt++;
    if (sopCyc - rdReqCyc != 3)
      $display("FAIL rd_latency: got %0d cycles want 3", sopCyc - rdReqCyc);
    else passCnt++;
    totalCnt++;
    if (beatCnt != 3) $display("FAIL rd_beats: got %0d want 3", beatCnt);
    else passCnt++;
  endtask

  task automatic test_stall();
    readyMode = 1;
    runDirectedRead();
    readyMode = 0;
    totalCnt++;
    if (obsQ.size() != 1) $display("FAIL stall_count: got %0d events want 1", obsQ.size());
    else passCnt++;
    if (obsQ.size() > 0) begin
      totalCnt++;
      if (obsQ[0].b0 !== 64'h01000004_4A000001 || obsQ[0].b1 !== 64'h00000000_01002A18 ||
          obsQ[0].b2 !== 64'h00000000_CAFEF00D)
        $display("FAIL stall_beats: got %h %h %h", obsQ[0].b0, obsQ[0].b1, obsQ[0].b2);
      else passCnt++;
    end
    totalCnt++;
    if (beatCnt != 3) $display("FAIL stall_accepted: got %0d want 3", beatCnt);
    else passCnt++;
    totalCnt++;
    if (stallErr != 0) $display("FAIL stall_stable: got %0d violations want 0", stallErr);
    else passCnt++;
    totalCnt++;
    if (tlpErr != 0) $display("FAIL stall_gap: got %0d gaps want 0", tlpErr);
    else passCnt++;
  endtask

  task automatic test_overflow();
    Action a;
    seedRegs();
    readyMode = 2;
    rdHold    = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      a = randAct((i == 0) ? 1 : int'($urandom_range(1, 2)));
      if (i < 9) modelAct(a);
      actData  = a;
      actValid = 1'b1;
      @(posedge clk);
      #1;
      if (i == 8) begin
        totalCnt++;
        if (actOverflow !== 1'b0) $display("FAIL ovf_nine: got %b want 0", actOverflow);
        else passCnt++;
      end
    end
    actValid = 1'b0;
    totalCnt++;
    if (actOverflow !== 1'b1) $display("FAIL ovf_tenth: got %b want 1", actOverflow);
    else passCnt++;
    repeat (5) @(posedge clk);
    #1;
    rdHold = 0;
    for (int i = 0; i < 3000 && obsQ.size() < expQ.size(); i++) @(negedge clk);
    repeat (20) @(negedge clk);
    totalCnt++;
    if (obsQ.size() != expQ.size())
      $display("FAIL ovf_count: got %0d events want %0d", obsQ.size(), expQ.size());
    else passCnt++;
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      totalCnt++;
      if (obsQ[i].isCpl !== expQ[i].isCpl || obsQ[i].b0 !== expQ[i].b0 ||
          obsQ[i].b1 !== expQ[i].b1 || obsQ[i].b2 !== expQ[i].b2)
        $display("FAIL ovf_event%0d: got %b %h %h %h want %b %h %h %h", i, obsQ[i].isCpl,
                 obsQ[i].b0, obsQ[i].b1, obsQ[i].b2, expQ[i].isCpl, expQ[i].b0, expQ[i].b1,
                 expQ[i].b2);
      else passCnt++;
    end
    totalCnt++;
    if (actOverflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", actOverflow);
    else passCnt++;
    readyMode = 0;
  endtask

  task automatic test_interleave();
    Action a;
    seedRegs();
    readyMode = 2;
    stallErr  = 0;
    tlpErr    = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      a = randAct((i == 1) ? 2 : 1);
      modelAct(a);
      pushAct(a);
    end
    for (int i = 0; i < 2000 && obsQ.size() < expQ.size(); i++) @(negedge clk);
    repeat (10) @(negedge clk);
    totalCnt++;
    if (obsQ.size() != 3) $display("FAIL il_count: got %0d events want 3", obsQ.size());
    else passCnt++;
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      totalCnt++;
      if (obsQ[i].isCpl !== expQ[i].isCpl || obsQ[i].b0 !== expQ[i].b0 ||
          obsQ[i].b1 !== expQ[i].b1 || obsQ[i].b2 !== expQ[i].b2)
        $display("FAIL il_event%0d: got %b %h %h %h want %b %h %h %h", i, obsQ[i].isCpl,
                 obsQ[i].b0, obsQ[i].b1, obsQ[i].b2, expQ[i].isCpl, expQ[i].b0, expQ[i].b1,
                 expQ[i].b2);
      else passCnt++;
    end
    if (obsQ.size() >= 2) begin
      totalCnt++;
      if (obsQ[1].cycle <= obsQ[0].cycle)
        $display("FAIL il_order: write at cycle %0d want after EOP cycle %0d", obsQ[1].cycle,
                 obsQ[0].cycle);
      else passCnt++;
    end
    totalCnt++;
    if (stallErr != 0 || tlpErr != 0)
      $display("FAIL il_protocol: got %0d stall, %0d gap errors want 0 0", stallErr, tlpErr);
    else passCnt++;
    readyMode = 0;
  endtask

  task automatic test_random();
    Action a;
    int    burst;
    seedRegs();
    busDev    = 13'($urandom);
    readyMode = 2;
    stallErr  = 0;
    tlpErr    = 0;
    @(posedge clk);
    #1;
    for (int b = 0; b < 5; b++) begin
      burst = int'($urandom_range(1, 8));
      for (int i = 0; i < burst; i++) begin
        a = randAct(-1);
        modelAct(a);
        pushAct(a);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      for (int i = 0; i < 3000 && obsQ.size() < expQ.size(); i++) @(negedge clk);
      repeat (6) @(posedge clk);
      #1;
    end
    totalCnt++;
    if (obsQ.size() != expQ.size())
      $display("FAIL rnd_count: got %0d events want %0d", obsQ.size(), expQ.size());
    else passCnt++;
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      totalCnt++;
      if (obsQ[i].isCpl !== expQ[i].isCpl || obsQ[i].b0 !== expQ[i].b0 ||
          obsQ[i].b1 !== expQ[i].b1 || obsQ[i].b2 !== expQ[i].b2)
        $display("FAIL rnd_event%0d: got %b %h %h %h want %b %h %h %h", i, obsQ[i].isCpl,
                 obsQ[i].b0, obsQ[i].b1, obsQ[i].b2, expQ[i].isCpl, expQ[i].b0, expQ[i].b1,
                 expQ[i].b2);
      else passCnt++;
    end
    totalCnt++;
    if (stallErr != 0 || tlpErr != 0)
      $display("FAIL rnd_protocol: got %0d stall, %0d gap errors want 0 0", stallErr, tlpErr);
    else passCnt++;
    totalCnt++;
    if (actOverflow !== 1'b0) $display("FAIL rnd_overflow: got %b want 0", actOverflow);
    else passCnt++;
    readyMode = 0;
    busDev    = {8'h01, 5'h00};
  endtask

  task automatic test_reset_mid();
    bit found;
    seedRegs();
    readyMode = 0;
    rdLat     = 1;
    found     = 0;
    @(posedge clk);
    #1;
    pushAct(randAct(1));
    pushAct(randAct(2));
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (txIf.txValid && !txIf.txSOP && !txIf.txEOP) found = 1;
    end
    totalCnt++;
    if (!found) $display("FAIL midrst_reach: got no second beat want one");
    else passCnt++;
    #2;
    rstN = 1'b0;
    #1;
    totalCnt++;
    if (txIf.txValid !== 1'b0) $display("FAIL midrst_async: got txValid %b want 0", txIf.txValid);
    else passCnt++;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    obsQ.delete();
    beatCnt = 0;
    repeat (20) @(negedge clk);
    totalCnt++;
    if (obsQ.size() != 0 || beatCnt != 0)
      $display("FAIL midrst_quiet: got %0d events %0d beats want 0 0", obsQ.size(), beatCnt);
    else passCnt++;
    @(posedge clk);
    #1;
    pushAct(mkAct(2'd2, 4'd9, 16'h0, 8'h0, 32'h1234_5678));
    repeat (5) @(negedge clk);
    totalCnt++;
    if (obsQ.size() != 1) $display("FAIL midrst_empty: got %0d events want 1", obsQ.size());
    else passCnt++;
    if (obsQ.size() > 0) begin
      totalCnt++;
      if (obsQ[0].b0 !== {28'h0, 4'd9, 32'h1234_5678})
        $display("FAIL midrst_write: got %h want 0000000912345678", obsQ[0].b0);
      else passCnt++;
    end
    rdLat = 0;
  endtask

  initial begin
    seedRegs();
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_overflow();
    test_reset();
    test_interleave();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passCnt, totalCnt);
    $fatal(1);
  end

endmodule
